// File: rtl/fpu_result_uart_tx.sv
// Serial transmitter for 16-bit FPU results: buffers one pending word and
// sends each word as two back-to-back 8N1 frames at a runtime bit period.
module fpu_result_uart_tx #(
    parameter bit HIGH_BYTE_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [15:0] CLKS_PER_BIT,
    input  logic [15:0] result_i,
    input  logic        result_valid_i,
    output logic        result_ready_o,
    output logic        r_Tx_Serial,
    output logic        tx_active_o,
    output logic        tx_done_o
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] cpb_q, cpb_n;
    logic [15:0] word_q, word_n;
    logic [15:0] pend_q;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        byte_sel, byte_sel_n;
    logic        pend_full;
    logic        load;
    logic        accept;
    logic        cnt_last;
    logic        line_n;

    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return HIGH_BYTE_FIRST ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return HIGH_BYTE_FIRST ? w[7:0] : w[15:8];
    endfunction

    // A zero period would never let the counter wrap, so it runs at one cycle per bit.
    function automatic logic [15:0] clamp_cpb(input logic [15:0] c);
        return (c == 16'd0) ? 16'd1 : c;
    endfunction

    assign result_ready_o = ~pend_full;
    assign accept         = result_valid_i & ~pend_full;
    assign cnt_last       = (cnt == cpb_q - 16'd1);
    assign tx_active_o    = (state != IDLE);
    assign tx_done_o      = (state == STOP) && byte_sel && cnt_last;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        byte_sel_n = byte_sel;
        shreg_n    = shreg;
        cpb_n      = cpb_q;
        word_n     = word_q;
        load       = 1'b0;
        case (state)
            IDLE: load = pend_full;
            START: begin
                if (cnt_last) begin
                    cnt_n   = 16'd0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_n = 16'd0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = 3'd0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_n = 16'd0;
                    if (!byte_sel) begin
                        byte_sel_n = 1'b1;
                        shreg_n    = second_byte(word_q);
                        state_n    = START;
                    end else if (pend_full) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Word start: the rate is latched here so mid-word rate changes wait for the next word.
        if (load) begin
            cpb_n      = clamp_cpb(CLKS_PER_BIT);
            word_n     = pend_q;
            shreg_n    = first_byte(pend_q);
            byte_sel_n = 1'b0;
            bit_idx_n  = 3'd0;
            cnt_n      = 16'd0;
            state_n    = START;
        end

        // The line register carries the level belonging to the state being entered.
        if (state_n == START) begin
            line_n = 1'b0;
        end else if (state_n == DATA) begin
            line_n = shreg_n[0];
        end else begin
            line_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state       <= IDLE;
            pend_full   <= 1'b0;
            r_Tx_Serial <= 1'b1;
        end else begin
            state       <= state_n;
            r_Tx_Serial <= line_n;
            if (load) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pend_q <= result_i;
        end
        cnt      <= cnt_n;
        cpb_q    <= cpb_n;
        word_q   <= word_n;
        shreg    <= shreg_n;
        bit_idx  <= bit_idx_n;
        byte_sel <= byte_sel_n;
    end

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Bench for fpu_result_uart_tx: word-level line model checked every cycle,
// directed scenarios with literal timing/bit expectations and a loopback receiver.
module tb_fpu_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [15:0] cpb = 16'd4;
    logic [15:0] result = 16'h1234;
    logic [15:0] result1 = 16'h0000;
    logic        valid = 1'b1;
    logic        valid1 = 1'b0;
    logic        ready, line, active, done;
    logic        ready1, line1, active1, done1;

    always #5 clk = ~clk;

    fpu_result_uart_tx #(.HIGH_BYTE_FIRST(1'b1)) dut (
        .clk(clk), .rst_l(rst_l), .CLKS_PER_BIT(cpb), .result_i(result),
        .result_valid_i(valid), .result_ready_o(ready), .r_Tx_Serial(line),
        .tx_active_o(active), .tx_done_o(done)
    );

    fpu_result_uart_tx #(.HIGH_BYTE_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_l(rst_l), .CLKS_PER_BIT(cpb), .result_i(result1),
        .result_valid_i(valid1), .result_ready_o(ready1), .r_Tx_Serial(line1),
        .tx_active_o(active1), .tx_done_o(done1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_q[$];
    int done1_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word-level model: a word is 20*C line cycles laid out as two 10-bit frames.
    bit          m_busy = 1'b0;
    bit          m_pend_full = 1'b0;
    logic [15:0] m_pend = 16'h0;
    logic [15:0] m_word = 16'h0;
    int          m_c = 1;
    int          m_t = 0;

    function automatic logic frame_bit(input logic [15:0] w, input int c, input int t);
        int idx;
        int pos;
        logic [7:0] b;
        idx = t / c;
        pos = idx % 10;
        b = (idx < 10) ? w[15:8] : w[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task model_start();
        m_busy      = 1'b1;
        m_t         = 0;
        m_word      = m_pend;
        m_c         = (cpb == 16'd0) ? 1 : int'(cpb);
        m_pend_full = 1'b0;
    endtask

    always @(posedge clk) begin : model
        bit acc;
        cyc = cyc + 1;
        if (!rst_l) begin
            m_busy      = 1'b0;
            m_pend_full = 1'b0;
        end else begin
            acc = valid && !m_pend_full;
            if (m_busy) begin
                m_t = m_t + 1;
                if (m_t == 20 * m_c) begin
                    if (m_pend_full) model_start();
                    else m_busy = 1'b0;
                end
            end else if (m_pend_full) begin
                model_start();
            end
            if (acc) begin
                m_pend_full = 1'b1;
                m_pend      = result;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_line;
        logic exp_done;
        if (cyc >= 1) begin
            exp_line = m_busy ? frame_bit(m_word, m_c, m_t) : 1'b1;
            exp_done = m_busy && (m_t == 20 * m_c - 1);
            chk("line", line, exp_line);
            chk("active", active, m_busy);
            chk("done", done, exp_done);
            chk("ready", ready, !m_pend_full);
            if (done === 1'b1) done_q.push_back(cyc);
            if (done1 === 1'b1) done1_cnt++;
        end
    end

    // Loopback receivers: sample mid-bit after detecting the start edge.
    bit   rx_en = 1'b0;
    int   rx_c = 348;
    logic [7:0] rx0_q[$];
    logic [7:0] rx1_q[$];

    always begin : rx0
        logic [7:0] b;
        @(negedge clk);
        if (rx_en && line === 1'b0) begin
            repeat (rx_c / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (rx_c) @(negedge clk);
                b[i] = line;
            end
            repeat (rx_c) @(negedge clk);
            rx0_q.push_back(b);
        end
    end

    always begin : rx1
        logic [7:0] b;
        @(negedge clk);
        if (rx_en && line1 === 1'b0) begin
            repeat (rx_c / 2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (rx_c) @(negedge clk);
                b[j] = line1;
            end
            repeat (rx_c) @(negedge clk);
            rx1_q.push_back(b);
        end
    end

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, output int seen);
        bit got;
        got    = 1'b0;
        seen   = -1;
        result = w;
        valid  = 1'b1;
        for (int k = 0; k < 5000 && !got; k++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got  = 1'b1;
                seen = cyc;
            end
            drive_point();
        end
        valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted", w);
        end
    endtask

    task automatic wait_fall(output int t);
        bit found;
        found = 1'b0;
        t = -1;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (line === 1'b0) begin
                found = 1'b1;
                t = cyc;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_fall: line never went low");
        end
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int k = 0; k < budget && done_q.size() < n; k++) @(negedge clk);
        @(negedge clk);
        chk("done_count_reached", done_q.size(), n);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 20000 && !idle; k++) begin
            @(negedge clk);
            idle = (active === 1'b0) && (ready === 1'b1) && (active1 === 1'b0);
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: transmitter never went idle");
        end
        drive_point();
    endtask

    task automatic at_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin : main
        int t, f, f2, base;
        int sa, sb, sc, sd;
        logic [19:0] pat;

        // Reset held with valid asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_line", line, 1'b1);
            chk("rst_active", active, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_ready", ready, 1'b1);
        end
        drive_point();
        rst_l = 1'b1;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", ready, 1'b1);
        chk("post_rst_active", active, 1'b0);
        drive_point();

        // Single word 0x3C00 at 4 cycles per bit
        cpb  = 16'd4;
        base = done_q.size();
        send(16'h3C00, sa);
        wait_fall(f);
        chk("t2_fall_latency", f, sa + 2);
        pat = 20'b1000000000_1001111000;
        for (int i = 0; i < 20; i++) begin
            at_cycle(f + i * 4 + 2);
            chk($sformatf("t2_bit%0d", i), line, pat[i]);
        end
        wait_dones(base + 1, 200);
        chk("t2_done_time", done_q[base], f + 79);
        repeat (20) @(negedge clk);
        chk("t2_single_pulse", done_q.size(), base + 1);
        chk("t2_idle_line", line, 1'b1);
        drive_point();

        // Back-to-back with stall at 2 cycles per bit
        cpb  = 16'd2;
        base = done_q.size();
        send(16'h4248, sa);
        send(16'hC500, sb);
        send(16'h7BFF, sc);
        chk("t3_b_accept", sb - sa, 2);
        chk("t3_c_stall", sc - sa, 42);
        wait_dones(base + 3, 300);
        chk("t3_done0", done_q[base], sa + 41);
        chk("t3_gap01", done_q[base+1] - done_q[base], 40);
        chk("t3_gap12", done_q[base+2] - done_q[base+1], 40);
        wait_idle();

        // Rate latched at word start, then zero clamp
        cpb  = 16'd4;
        base = done_q.size();
        send(16'h1234, sa);
        wait_fall(f);
        at_cycle(f + 10);
        drive_point();
        cpb = 16'd8;
        send(16'hABCD, sb);
        wait_dones(base + 2, 400);
        chk("t4_first_len", done_q[base], f + 79);
        chk("t4_second_len", done_q[base+1] - done_q[base], 160);
        wait_idle();
        cpb  = 16'd0;
        base = done_q.size();
        send(16'h5555, sc);
        wait_fall(f2);
        wait_dones(base + 1, 100);
        chk("t4_zero_clamp", done_q[base] - f2, 19);
        wait_idle();

        // Reset during bit 3 of the first frame with a word pending
        cpb  = 16'd4;
        base = done_q.size();
        send(16'h00FF, sa);
        wait_fall(f);
        drive_point();
        send(16'hF00F, sb);
        at_cycle(f + 17);
        drive_point();
        rst_l = 1'b0;
        drive_point();
        rst_l = 1'b1;
        @(negedge clk);
        chk("t5_line_high", line, 1'b1);
        chk("t5_inactive", active, 1'b0);
        chk("t5_ready", ready, 1'b1);
        repeat (200) @(negedge clk);
        chk("t5_no_done", done_q.size(), base);
        chk("t5_pending_dropped", active, 1'b0);
        drive_point();

        // Loopback at 348 cycles per bit, both byte orders
        wait_idle();
        cpb   = 16'd348;
        rx_c  = 348;
        rx_en = 1'b1;
        chk("t6_ready_lo", ready1, 1'b1);
        result  = 16'h3C00;
        result1 = 16'h3C00;
        valid   = 1'b1;
        valid1  = 1'b1;
        drive_point();
        valid  = 1'b0;
        valid1 = 1'b0;
        for (int k = 0; k < 20 * 348 + 2000 && (rx0_q.size() < 2 || rx1_q.size() < 2); k++)
            @(negedge clk);
        chk("t6_rx_hi_count", rx0_q.size(), 2);
        chk("t6_rx_lo_count", rx1_q.size(), 2);
        if (rx0_q.size() >= 2) begin
            chk("t6_hi_byte0", rx0_q[0], 8'h3C);
            chk("t6_hi_byte1", rx0_q[1], 8'h00);
        end
        if (rx1_q.size() >= 2) begin
            chk("t6_lo_byte0", rx1_q[0], 8'h00);
            chk("t6_lo_byte1", rx1_q[1], 8'h3C);
        end
        repeat (400) @(negedge clk);
        chk("t6_lo_done_pulses", done1_cnt, 1);
        rx_en = 1'b0;
        sd = 0;
        chk("t6_lo_idle", active1 | sd[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
